msg_uart_rx: RTL and testbench
==============================

# msg_uart_rx

Serial front end for the order-processing datapath. It receives 8N1 UART bytes on a single input pin and assembles each group of 21 bytes into one 168-bit message. It then presents the message to the sequencer with a one-cycle valid strobe. This replaces the hard-coded message table and the next_msg button with a host-driven message stream.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- MSG_BYTES, default 21: bytes per message. The message width is MSG_BYTES*8 (168).
- TIMEOUT_CLKS, default 20*CLKS_PER_BIT: idle cycles allowed between bytes of one message.
- clk, input, 1: system clock. This is the only clock domain.
- rst, input, 1: asynchronous, active-high reset.
- rx, input, 1: UART line, asynchronous to clk, idle high.
- msg_out, output, 168: last complete message. Byte 0 received lands in [167:160], byte 20 in [7:0].
- msg_valid, output, 1: one-cycle pulse when msg_out has just been updated.
- frame_err, output, 1: one-cycle pulse when a partial message is discarded.
- msg_cnt, output, 8: count of valid messages, wraps 255→0.

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized signal rxs.
- Bit FSM states:
  - IDLE: on rxs==0, go to START and clear the bit timer.
  - START: at timer==CLKS_PER_BIT/2-1 (integer division), sample rxs.
    - If 0: go to DATA with the bit index at 0.
    - If 1: this is a glitch. Return to IDLE with no error and no state change elsewhere.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register. Bits arrive LSB first. After 8 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - If 1: the byte is good. Write it into the assembly register at position byte_cnt.
    - If 0: this is a framing error. Pulse frame_err, clear byte_cnt, and drop the assembled bytes.
    - Either way, return to IDLE.
- Message assembly:
  - byte_cnt runs 0..MSG_BYTES-1.
  - When a good byte arrives with byte_cnt==MSG_BYTES-1:
    - copy the full assembled value to msg_out;
    - pulse msg_valid;
    - increment msg_cnt;
    - clear byte_cnt.
  - Otherwise byte_cnt increments.
- Inter-byte timeout:
  - The timeout counter runs only while the FSM is in IDLE and byte_cnt>0. It clears on entry to START.
  - When it reaches TIMEOUT_CLKS, the partial message is discarded: pulse frame_err and clear byte_cnt.
  - When byte_cnt==0 the timeout counter is held at 0.
- msg_out holds its value between messages. There is no back-pressure; the consumer must take the message on the msg_valid cycle.
- A framing error on the last byte discards the whole message. msg_out and msg_cnt are unchanged.
- A new start bit may be detected in the first cycle after the STOP sample; there is no dead time.
- Reset mid-byte or mid-message: everything returns to reset values immediately, and no pulse is emitted.

## Timing
- Reset values:
  - msg_out=0, msg_valid=0, frame_err=0, msg_cnt=0;
  - FSM=IDLE, byte_cnt=0, timers=0, synchronizer=1.
- Pin to rxs latency: 2 cycles.
- Let t0 be the first cycle in which the FSM is in IDLE and sees rxs==0. Sample points are:
  - start sample at t0+CLKS_PER_BIT/2;
  - data bit i (i = 0..7) at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT;
  - stop sample at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- msg_valid, the msg_out update and the msg_cnt increment occur together, registered, on the cycle after the stop sample of the final byte.
- frame_err goes high on the cycle after the failing stop sample, or on the cycle after the timeout counter reaches TIMEOUT_CLKS. It is never high in the same cycle as msg_valid.
- Tolerance: correct reception with up to ±3% baud mismatch.

## Test plan
All scenarios use CLKS_PER_BIT=8 and TIMEOUT_CLKS=160.
- **Reset then one message.** Send the 21 bytes 00 00 00 00 00 00 01 00 00 00 60 00 00 00 00 00 00 00 00 00 00.
  - Expect exactly one msg_valid at stop sample+1.
  - Expect msg_out == {24'd0, 32'd1, 32'd96, 32'd0, 8'd0, 32'd0, 8'd0} and msg_cnt=1.
- **Back-to-back messages.** Send 4 messages with no idle gap between stop and start bits.
  - Expect 4 msg_valid pulses and msg_cnt=4.
  - The final msg_out equals the 4th message; frame_err never fires.
- **Framing error.** Drive the stop bit of byte 10 low.
  - Expect a frame_err pulse and no msg_valid.
  - Then send a complete message: it is received correctly and msg_cnt increments by exactly 1.
- **Inter-byte timeout.** Send 5 bytes, then hold rx high for 161 cycles.
  - Expect frame_err at the 160th idle cycle+1.
  - The following full message is received with the correct byte alignment.
- **Start-bit glitch.** Pulse rx low for 2 cycles while idle.
  - Expect no FSM advance past START, no error, and no change to byte_cnt.
- **Reset mid-message, then wrap.** Assert rst during byte 7.
  - All outputs read 0 and the next message is received cleanly.
  - Then send 256 messages: msg_cnt reads 0 after the wrap.

Source files
------------

// File: rtl/msg_uart_rx.sv
// msg_uart_rx
// Receives 8N1 UART bytes on a single pin and assembles every MSG_BYTES
// bytes into one message. The first byte received lands in the most
// significant byte of msg_out. A partial message is dropped on a bad stop
// bit or when the line stays idle too long between bytes.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   MSG_BYTES     bytes per message
//   TIMEOUT_CLKS  idle cycles allowed between bytes of one message
// Ports:
//   clk        system clock; the only clock domain
//   rst        asynchronous active-high reset
//   rx         UART line, asynchronous to clk, idle high
//   msg_out    last complete message, held between messages
//   msg_valid  one-cycle pulse when msg_out has just been updated
//   frame_err  one-cycle pulse when a partial message is discarded
//   msg_cnt    count of complete messages, wraps 255 -> 0
module msg_uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MSG_BYTES    = 21,
  parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [MSG_BYTES*8-1:0] msg_out,
  output logic                   msg_valid,
  output logic                   frame_err,
  output logic [7:0]             msg_cnt
);

  localparam int MSG_W   = MSG_BYTES * 8;
  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   BYTE_LAST = CNT_W'(MSG_BYTES - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer; both flops reset to the idle (high) line level
  // ---------------------------------------------------------------------
  logic rx_meta_reg;
  logic rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rxs         <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs         <= rx_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Bit-level FSM
  // ---------------------------------------------------------------------
  state_t               state_reg;
  state_t               state_next;
  logic [TIMER_W-1:0]   timer_reg;
  logic [2:0]           bit_idx_reg;
  logic [7:0]           shift_reg;

  logic half_tick;
  logic bit_tick;
  assign half_tick = (timer_reg == HALF_LAST);
  assign bit_tick  = (timer_reg == BIT_LAST);

  // Strobes decoded from the current state
  logic timer_clr;
  logic start_seen;
  logic start_ok;
  logic shift_en;
  logic stop_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!rxs) state_next = S_START;
      // A start bit that is high again at mid-bit is a glitch: go back quietly
      S_START: if (half_tick) state_next = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (bit_tick && (bit_idx_reg == 3'd7)) state_next = S_STOP;
      S_STOP:  if (bit_tick) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    timer_clr  = 1'b0;
    start_seen = 1'b0;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Timer sits at zero in IDLE so START begins counting from 0
        timer_clr  = 1'b1;
        start_seen = ~rxs;
      end
      S_START: begin
        if (half_tick) begin
          timer_clr = 1'b1;
          start_ok  = ~rxs;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          stop_en   = 1'b1;
        end
      end
      default: timer_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      timer_reg <= timer_clr ? '0 : timer_reg + TIMER_W'(1);
      if (start_ok) begin
        bit_idx_reg <= '0;
      end else if (shift_en) begin
        bit_idx_reg <= bit_idx_reg + 3'd1;
      end
      // LSB arrives first, so shift in from the top
      if (shift_en) begin
        shift_reg <= {rxs, shift_reg[7:1]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Message assembly and inter-byte timeout
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [MSG_W-1:0] asm_reg;
  logic [MSG_W-1:0] asm_next;

  logic byte_good;
  logic byte_bad;
  logic last_byte;
  logic timeout_hit;

  assign byte_good   = stop_en & rxs;
  assign byte_bad    = stop_en & ~rxs;
  assign last_byte   = (byte_cnt_reg == BYTE_LAST);
  // A start seen in the same cycle wins over the timeout
  assign timeout_hit = (state_reg == S_IDLE) && rxs && (byte_cnt_reg != '0) &&
                       (to_cnt_reg == TO_LAST);

  // Assembly value with the freshly received byte dropped into its lane
  genvar gi;
  generate
    for (gi = 0; gi < MSG_BYTES; gi++) begin : g_lane
      localparam int LO = (MSG_BYTES - 1 - gi) * 8;
      assign asm_next[LO +: 8] = (byte_cnt_reg == CNT_W'(gi)) ? shift_reg
                                                              : asm_reg[LO +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg <= '0;
    end else if (start_seen || (byte_cnt_reg == '0) || timeout_hit) begin
      to_cnt_reg <= '0;
    end else if (state_reg == S_IDLE) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      msg_out      <= '0;
      msg_valid    <= 1'b0;
      frame_err    <= 1'b0;
      msg_cnt      <= '0;
    end else begin
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
      if (byte_good) begin
        if (last_byte) begin
          msg_out      <= asm_next;
          msg_valid    <= 1'b1;
          msg_cnt      <= msg_cnt + 8'd1;
          byte_cnt_reg <= '0;
          asm_reg      <= '0;
        end else begin
          asm_reg      <= asm_next;
          byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
        end
      end else if (byte_bad || timeout_hit) begin
        // Drop the partial message; msg_out and msg_cnt stay as they were
        frame_err    <= 1'b1;
        byte_cnt_reg <= '0;
        asm_reg      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_msg_uart_rx.sv
`timescale 1ns/1ps
module tb_msg_uart_rx;

  // Instance A: 21-byte messages, 8 clocks per bit
  localparam int CPB_A = 8;
  localparam int NB_A  = 21;
  localparam int TO_A  = 160;
  // Instance B: short messages at the fastest rate, used for the counter wrap
  localparam int CPB_B = 4;
  localparam int NB_B  = 2;
  localparam int TO_B  = 80;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [NB_A*8-1:0] msg_out_a;
  logic              msg_valid_a;
  logic              frame_err_a;
  logic [7:0]        msg_cnt_a;
  logic [NB_B*8-1:0] msg_out_b;
  logic              msg_valid_b;
  logic              frame_err_b;
  logic [7:0]        msg_cnt_b;

  msg_uart_rx #(.CLKS_PER_BIT(CPB_A), .MSG_BYTES(NB_A), .TIMEOUT_CLKS(TO_A)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_a),
    .msg_out(msg_out_a), .msg_valid(msg_valid_a), .frame_err(frame_err_a), .msg_cnt(msg_cnt_a)
  );

  msg_uart_rx #(.CLKS_PER_BIT(CPB_B), .MSG_BYTES(NB_B), .TIMEOUT_CLKS(TO_B)) u_wrap (
    .clk(clk), .rst(rst), .rx(rx_b),
    .msg_out(msg_out_b), .msg_valid(msg_valid_b), .frame_err(frame_err_b), .msg_cnt(msg_cnt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           is_msg;
    int           cyc;
    logic [167:0] msg;
    logic [7:0]   cnt;
  } ev_t;

  ev_t exp_a[$];
  ev_t exp_b[$];

  // Reference model state, per instance
  int           part_n[2];
  logic [167:0] part_v[2];
  int           cnt_m[2];
  int           ref_c[2];   // cycle after which the idle timeout starts counting

  function automatic int cpb_of(input int w); return (w != 0) ? CPB_B : CPB_A; endfunction
  function automatic int nb_of(input int w);  return (w != 0) ? NB_B : NB_A;   endfunction
  function automatic int to_of(input int w);  return (w != 0) ? TO_B : TO_A;   endfunction

  task automatic chk(input string name, input logic [167:0] act, input logic [167:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int w, input ev_t e);
    if (w == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  // A partial message is dropped once TIMEOUT idle cycles have passed
  // without a new start bit being seen.
  task automatic model_timeout(input int w, input int t0);
    ev_t e;
    if (part_n[w] > 0 && (t0 - ref_c[w]) >= to_of(w) + 1) begin
      e.is_msg = 1'b0;
      e.cyc    = ref_c[w] + 1 + to_of(w);
      e.msg    = '0;
      e.cnt    = '0;
      push_ev(w, e);
      part_n[w] = 0;
      part_v[w] = '0;
    end
  endtask

  task automatic set_rx(input int w, input logic v);
    if (w == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge right after the stop bit.
  task automatic send_byte(input int w, input logic [7:0] b, input bit stop_ok);
    int  c  = cpb_of(w);
    int  n0 = cyc;
    int  s;
    ev_t e;
    model_timeout(w, n0 + 2);
    // Pin reaches the FSM two cycles later; stop sample is 9.5 bits after that
    s = n0 + 2 + c / 2 + 9 * c;
    ref_c[w] = s;
    if (!stop_ok) begin
      e.is_msg = 1'b0; e.cyc = s + 1; e.msg = '0; e.cnt = '0;
      push_ev(w, e);
      part_n[w] = 0;
      part_v[w] = '0;
    end else begin
      part_v[w] = {part_v[w][159:0], b};
      part_n[w]++;
      if (part_n[w] == nb_of(w)) begin
        cnt_m[w]++;
        e.is_msg = 1'b1; e.cyc = s + 1; e.msg = part_v[w]; e.cnt = 8'(cnt_m[w]);
        push_ev(w, e);
        part_n[w] = 0;
        part_v[w] = '0;
      end
    end
    set_rx(w, 1'b0);
    wait_neg(c);
    for (int i = 0; i < 8; i++) begin
      set_rx(w, b[i]);
      wait_neg(c);
    end
    set_rx(w, stop_ok);
    wait_neg(c);
    set_rx(w, 1'b1);
  endtask

  task automatic send_msg(input int w, input logic [167:0] v);
    int nb = nb_of(w);
    for (int k = 0; k < nb; k++) send_byte(w, v[(nb - 1 - k) * 8 +: 8], 1'b1);
  endtask

  task automatic idle(input int w, input int n);
    model_timeout(w, cyc + n + 2);
    wait_neg(n);
  endtask

  // Two-cycle low pulse: rejected at the mid-start sample
  task automatic glitch(input int w);
    model_timeout(w, cyc + 2);
    ref_c[w] = cyc + 2 + cpb_of(w) / 2;
    set_rx(w, 1'b0);
    wait_neg(2);
    set_rx(w, 1'b1);
    wait_neg(cpb_of(w) + 2);
  endtask

  function automatic logic [167:0] rand_msg(input int w);
    logic [167:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[135:0], 32'($urandom)};
    if (w != 0) v = {152'd0, v[15:0]};
    return v;
  endfunction

  task automatic wait_drain();
    int k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_a", 168'(exp_a.size()), '0);
    chk("drain_b", 168'(exp_b.size()), '0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    #1;
    chk("rst_msg_out_a", msg_out_a, '0);
    chk("rst_valid_a", msg_valid_a, '0);
    chk("rst_err_a", frame_err_a, '0);
    chk("rst_cnt_a", msg_cnt_a, '0);
    chk("rst_msg_out_b", msg_out_b, '0);
    chk("rst_cnt_b", msg_cnt_b, '0);
    for (int w = 0; w < 2; w++) begin
      part_n[w] = 0;
      part_v[w] = '0;
      cnt_m[w]  = 0;
      ref_c[w]  = 0;
    end
    wait_neg(3);
    rst = 1'b0;
    wait_neg(2);
  endtask

  // Scoreboard monitor: pops an expectation whenever a DUT strobes an output
  task automatic check_event(input int w, input logic v, input logic f,
                             input logic [167:0] mo, input logic [7:0] mc);
    ev_t   e;
    string p = (w != 0) ? "b" : "a";
    if (v || f) begin
      chk({p, "_valid_with_err"}, 168'(v & f), '0);
      if ((w == 0 && exp_a.size() == 0) || (w != 0 && exp_b.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected valid=%0b err=%0b required=none cycle=%0d", p, v, f, cyc);
      end else begin
        e = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
        $display("event %s %s cycle=%0d cnt=%0d msg=%0h", p, v ? "msg" : "err", cyc, mc, mo);
        chk({p, "_kind"}, 168'(v), 168'(e.is_msg));
        chk({p, "_cycle"}, 168'(cyc), 168'(e.cyc));
        if (e.is_msg) begin
          chk({p, "_msg"}, mo, e.msg);
          chk({p, "_cnt"}, 168'(mc), 168'(e.cnt));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_event(0, msg_valid_a, frame_err_a, 168'(msg_out_a), msg_cnt_a);
      check_event(1, msg_valid_b, frame_err_b, 168'(msg_out_b), msg_cnt_b);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   s1_bytes[21];
    logic [167:0] spec_msg;
    logic [167:0] m;
    s1_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h60,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    spec_msg = {24'd0, 32'd1, 32'd96, 32'd0, 8'd0, 32'd0, 8'd0};

    // Reset state
    wait_neg(2);
    do_reset();

    // Reset then one fixed message
    for (int k = 0; k < 21; k++) send_byte(0, s1_bytes[k], 1'b1);
    wait_drain();
    chk("s1_msg_out", msg_out_a, spec_msg);
    chk("s1_cnt", 168'(msg_cnt_a), 168'd1);

    // Four back-to-back messages, no gap between stop and start
    m = '0;
    for (int n = 0; n < 4; n++) begin
      m = rand_msg(0);
      send_msg(0, m);
    end
    wait_drain();
    chk("s2_last_msg", msg_out_a, m);
    chk("s2_cnt", 168'(msg_cnt_a), 168'd5);

    // Framing error on byte 10, then a clean message
    for (int k = 0; k < 10; k++) send_byte(0, 8'($urandom), 1'b1);
    send_byte(0, 8'($urandom), 1'b0);
    idle(0, 20);
    m = rand_msg(0);
    send_msg(0, m);
    wait_drain();
    chk("s3_msg", msg_out_a, m);
    chk("s3_cnt", 168'(msg_cnt_a), 168'd6);

    // Inter-byte timeout after 5 bytes, then a clean message
    for (int k = 0; k < 5; k++) send_byte(0, 8'($urandom), 1'b1);
    idle(0, 200);
    m = rand_msg(0);
    send_msg(0, m);
    wait_drain();
    chk("s4_msg", msg_out_a, m);
    chk("s4_cnt", 168'(msg_cnt_a), 168'd7);

    // Start-bit glitches between messages and in the middle of one
    idle(0, 20);
    glitch(0);
    idle(0, 10);
    m = rand_msg(0);
    for (int k = 0; k < NB_A; k++) begin
      if (k == 3) begin
        idle(0, 10);
        glitch(0);
        idle(0, 10);
      end
      send_byte(0, m[(NB_A - 1 - k) * 8 +: 8], 1'b1);
    end
    wait_drain();
    chk("s5_msg", msg_out_a, m);
    chk("s5_cnt", 168'(msg_cnt_a), 168'd8);

    // Reset during byte 7, then a clean message
    for (int k = 0; k < 7; k++) send_byte(0, 8'($urandom), 1'b1);
    set_rx(0, 1'b0);
    wait_neg(CPB_A);
    set_rx(0, 1'b1);
    wait_neg(CPB_A);
    set_rx(0, 1'b0);
    wait_neg(CPB_A / 2);
    do_reset();
    idle(0, 10);
    m = rand_msg(0);
    send_msg(0, m);
    wait_drain();
    chk("s6_msg", msg_out_a, m);
    chk("s6_cnt", 168'(msg_cnt_a), 168'd1);

    // 256 messages on the short-message instance: counter wraps to 0
    m = '0;
    for (int n = 0; n < 256; n++) begin
      m = rand_msg(1);
      send_msg(1, m);
    end
    wait_drain();
    chk("wrap_cnt", 168'(msg_cnt_b), 168'd0);
    chk("wrap_msg", 168'(msg_out_b), m);
    chk("a_cnt_untouched", 168'(msg_cnt_a), 168'd1);

    idle(0, 20);
    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
